// File: rtl/ucode_loader_pkg.sv
// Shared constants and state encoding for the writable-control-store loader.
// Defaults track the control-store word width and the micro-address width.
package ucode_loader_pkg;

  localparam int unsigned CtrlStoreWordW = 24;
  localparam int unsigned MicroAddrW     = 5;

  typedef enum logic [2:0] {
    StIdle,
    StRecv,
    StWrite,
    StCheck,
    StDone
  } state_t;

  function automatic int unsigned bytes_per_word(int unsigned word_w);
    return (word_w + 7) / 8;
  endfunction

endpackage

// File: rtl/ucode_loader_if.sv
// Byte-stream valid/ready link from the host/debug port into the loader.
interface ucode_loader_if;

  logic       valid;
  logic [7:0] data;
  logic       ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/ucode_loader_byte_packer.sv
// Assembles little-endian bytes into one word; word_ready pulses combinationally
// on the accept of the final byte, with word already including that byte.
module byte_packer import ucode_loader_pkg::*; #(
  parameter int unsigned WORD_W = CtrlStoreWordW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              accept,
  input  logic [7:0]        data,
  output logic [WORD_W-1:0] word,
  output logic              word_ready
);

  localparam int unsigned BYTES = bytes_per_word(WORD_W);
  localparam int unsigned BufW  = 8 * BYTES;
  localparam int unsigned CntW  = (BYTES > 1) ? $clog2(BYTES) : 1;

  logic [BufW-1:0] shreg_q, shreg_shift;
  logic [CntW-1:0] cnt_q;
  logic            last;

  // New bytes enter at the top, so after BYTES shifts byte 0 sits in bits [7:0].
  assign shreg_shift = (shreg_q >> 8) | (BufW'(data) << (BufW - 8));
  assign word        = shreg_shift[WORD_W-1:0];
  assign last        = (cnt_q == CntW'(BYTES - 1));
  assign word_ready  = accept && last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      shreg_q <= '0;
    end else if (clr) begin
      cnt_q   <= '0;
    end else if (accept) begin
      shreg_q <= shreg_shift;
      cnt_q   <= last ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/ucode_loader.sv
// Control-store loader: byte stream in, sequential word writes from address 0 out.
// Define UCODE_LOADER_CHECKSUM_EN to add a trailing XOR checksum byte and the err port.
module ucode_loader import ucode_loader_pkg::*; #(
  parameter int unsigned WORD_W = CtrlStoreWordW,
  parameter int unsigned ADDR_W = MicroAddrW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   load_len,
  ucode_loader_if.slave     src,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WORD_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              ctrl_hold
`ifdef UCODE_LOADER_CHECKSUM_EN
  ,
  output logic              err
`endif
);

  state_t              state_q, state_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [ADDR_W:0]     word_cnt_q, word_cnt_d;
  logic                wr_en_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [WORD_W-1:0]   wr_data_q;
  logic                clr, accept, pk_accept, word_ready;
  logic [WORD_W-1:0]   word;
`ifdef UCODE_LOADER_CHECKSUM_EN
  logic [7:0]          csum_q, csum_d;
  logic                err_q, err_d;
`endif

  assign accept    = src.valid && src.ready;
  assign pk_accept = accept && (state_q == StRecv);

  byte_packer #(.WORD_W(WORD_W)) u_packer (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .accept     (pk_accept),
    .data       (src.data),
    .word       (word),
    .word_ready (word_ready)
  );

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    clr        = 1'b0;
`ifdef UCODE_LOADER_CHECKSUM_EN
    csum_d     = csum_q;
    err_d      = err_q;
`endif
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          len_d      = load_len;
          word_cnt_d = '0;
          clr        = 1'b1;
`ifdef UCODE_LOADER_CHECKSUM_EN
          csum_d     = '0;
          err_d      = 1'b0;
`endif
          state_d    = (load_len == '0) ? StDone : StRecv;
        end
      end
      StRecv: begin
`ifdef UCODE_LOADER_CHECKSUM_EN
        if (accept) csum_d = csum_q ^ src.data;
`endif
        if (word_ready) state_d = StWrite;
      end
      StWrite: begin
        // Counter is ADDR_W+1 wide so a full-store load reaches len without wrapping.
        word_cnt_d = word_cnt_q + 1'b1;
        if (word_cnt_d == len_q) begin
`ifdef UCODE_LOADER_CHECKSUM_EN
          state_d = StCheck;
`else
          state_d = StDone;
`endif
        end else begin
          state_d = StRecv;
        end
      end
`ifdef UCODE_LOADER_CHECKSUM_EN
      StCheck: begin
        if (accept) begin
          err_d   = (src.data != csum_q);
          state_d = StDone;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      len_q      <= '0;
      word_cnt_q <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
`ifdef UCODE_LOADER_CHECKSUM_EN
      csum_q     <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_cnt_q <= word_cnt_d;
      wr_en_q    <= word_ready;
      if (word_ready) begin
        wr_addr_q <= word_cnt_q[ADDR_W-1:0];
        wr_data_q <= word;
      end
`ifdef UCODE_LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
      err_q      <= err_d;
`endif
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy    = (state_q == StRecv) || (state_q == StWrite) || (state_q == StCheck);
  assign done    = (state_q == StDone);

`ifdef UCODE_LOADER_CHECKSUM_EN
  assign src.ready = (state_q == StRecv) || (state_q == StCheck);
  assign ctrl_hold = (state_q != StDone) || err_q;
  assign err       = err_q;
`else
  assign src.ready = (state_q == StRecv);
  assign ctrl_hold = (state_q != StDone);
`endif

endmodule

// File: doc/ucode_loader.md
# ucode_loader

Writable-control-store loader for the microprogrammed control unit. Receives microcode as a byte stream over a valid/ready handshake, assembles bytes into microinstruction words and writes them sequentially into the control store from address 0. Holds the control unit off (`ctrl_hold`) until the load completes. Sits between the host/debug byte link and the control-store write port.

## Interface
- `WORD_W`, 24: microinstruction word width (store word size).
- `ADDR_W`, 5: control-store address width (micro address size).
- `BYTES`, derived, ceil(WORD_W/8): bytes per word; not overridable.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  one-cycle request to begin a load; sampled only in IDLE or DONE.
- `load_len`  in  ADDR_W+1  number of words to load, 0..2^ADDR_W; sampled with `start`.
- `in_valid`  in  1  byte available on `in_data`.
- `in_data`  in  8  stream byte.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `wr_en`  out  1  control-store write strobe, one cycle per word.
- `wr_addr`  out  ADDR_W  write address.
- `wr_data`  out  WORD_W  write data.
- `busy`  out  1  load in progress.
- `done`  out  1  sticky: last load completed.
- `ctrl_hold`  out  1  stall to control unit; high from reset until first successful load.

## Operation
- States: IDLE, RECV, WRITE, CHECK (only with checksum), DONE.
- IDLE/DONE + `start`: latch `load_len`, clear word/byte counters, clear `done`; `load_len`=0 -> DONE next cycle, no writes; else -> RECV.
- RECV: `in_ready`=1. Byte accepted on `in_valid && in_ready`. Bytes little-endian: byte k fills bits [8k+7:8k]; bits above WORD_W-1 in the last byte discarded. After byte BYTES-1 accepted -> WRITE.
- WRITE: `in_ready`=0; `wr_en`=1 for exactly one cycle with `wr_addr`=word counter, `wr_data`=assembled word. Then word counter +1; if counter reaches `load_len` -> CHECK (if enabled) else DONE; otherwise -> RECV.
- DONE: `done`=1, `busy`=0, `ctrl_hold`=0.
- `start` in RECV/WRITE/CHECK ignored.
- `ctrl_hold` = 1 in every state other than DONE; also 1 in DONE if load failed checksum.
- `load_len`=2^ADDR_W: counter must reach full width without wrap before compare; last write to address 2^ADDR_W-1.

## Timing
- Reset values: state IDLE, `in_ready`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `busy`=0, `done`=0, `ctrl_hold`=1.
- `start` -> RECV: 1 cycle; `in_ready` high the cycle after `start`.
- Minimum per word: BYTES accept cycles + 1 WRITE cycle; back-to-back `in_valid` gives BYTES+1 cycles/word.
- `wr_en` registered; `wr_addr`/`wr_data` stable during the `wr_en` cycle.
- `in_valid` low stalls RECV indefinitely; no timeout.
- Reset mid-load: immediate return to IDLE, partial word dropped, `ctrl_hold`=1; control-store contents already written left as is.

## Configuration
- `UCODE_LOADER_CHECKSUM_EN` defined: after the last word, CHECK state accepts one extra byte (`in_ready`=1) = XOR of all data bytes of the load. Match -> DONE with `err`=0; mismatch -> DONE with `err`=1 and `ctrl_hold` kept 1. Adds port `err` out 1, reset 0, cleared on `start`.
- Undefined: no CHECK state, no `err` port, DONE entered directly after final WRITE.

## Structure
- Shared package/constants file: state encoding defines, `WORD_W`/`ADDR_W` defaults tied to the control-store word and micro-address sizes.
- One natural sub-module: `byte_packer` (byte counter + shift-assembly into WORD_W, `word_ready` pulse). FSM, word counter, checksum in top.

## Test plan
- Reset asserted mid-RECV after 2 bytes -> `in_ready`=0, `busy`=0, `ctrl_hold`=1 asynchronously; next load starts at `wr_addr`=0.
- `start`, `load_len`=2, bytes 0x11,0x22,0x33,0x44,0x55,0x66 back-to-back -> writes addr0=0x332211, addr1=0x665544; `done` at cycle 9 after `start`; `ctrl_hold`=0.
- `load_len`=0 -> no `wr_en`, `done`=1 one cycle after `start`.
- `in_valid` gapped randomly, `load_len`=32 -> 32 writes addr 0..31 in order, data matches stream, no wrap.
- `start` pulsed during RECV -> ignored; counters unchanged.
- With `UCODE_LOADER_CHECKSUM_EN`, `load_len`=1, bytes 0x01,0x02,0x04 then 0x07 -> `err`=0, `ctrl_hold`=0; checksum 0x00 -> `err`=1, `ctrl_hold`=1.
